lt24_sprite_compositor: RTL and testbench

//  Autonomous frame streamer for the LT24 (ILI9341) 16-bit 8080 LCD port.

---
 rtl/lt24_sprite_compositor_if.sv | 13 +
 rtl/lt24_sprite_compositor.sv | 254 +++++++++++++++++++++++++
 tb/tb_lt24_sprite_compositor.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lt24_sprite_compositor_if.sv
// LT24 8080-style parallel bus bundle.
// The master drives the bus lines; the slave receives them.
interface lt24_sprite_compositor_if;
  logic [15:0] d;
  logic        wr_n;
  logic        rd_n;
  logic        cs_n;
  logic        rs;
  logic        reset_n;

  modport master (output d, wr_n, rd_n, cs_n, rs, reset_n);
  modport slave  (input  d, wr_n, rd_n, cs_n, rs, reset_n);
endinterface

// File: rtl/lt24_sprite_compositor.sv
// LT24 frame streamer: CPU pass-through, or full frames of a tiled background
// overlaid with colour-keyed, priority-ordered sprites.
module lt24_sprite_compositor #(
  parameter int unsigned SCR_W       = 240,
  parameter int unsigned SCR_H       = 320,
  parameter int unsigned TILE_W_LOG2 = 6,
  parameter int unsigned TILE_H_LOG2 = 6,
  parameter int unsigned SPR_LOG2    = 6,
  parameter int unsigned NUM_SPRITES = 4,
  parameter logic [15:0] KEY_COLOR   = 16'hF81F
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_buffer_en,
  lt24_sprite_compositor_if.slave             i_bus,
  lt24_sprite_compositor_if.master            o_lcd,
  input  logic                                i_spr_wr,
  input  logic [2:0]                          i_spr_sel,
  input  logic [10:0]                         i_spr_x,
  input  logic [10:0]                         i_spr_y,
  input  logic                                i_spr_vis,
  output logic [TILE_W_LOG2+TILE_H_LOG2-1:0]  o_bg_addr,
  input  logic [15:0]                         i_bg_rdata,
  output logic [3+2*SPR_LOG2-1:0]             o_spr_addr,
  input  logic [15:0]                         i_spr_rdata,
  output logic                                o_frame_done,
  output logic [15:0]                         o_frame_cnt
);

  localparam int unsigned BgW  = TILE_W_LOG2 + TILE_H_LOG2;
  localparam int unsigned SprW = 3 + 2 * SPR_LOG2;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSetup = 2'd1;
  localparam logic [1:0] StPixel = 2'd2;

  localparam logic [10:0] XLast = 11'(SCR_W - 1);
  localparam logic [10:0] YLast = 11'(SCR_H - 1);
  localparam logic [15:0] WLast = 16'(SCR_W - 1);
  localparam logic [15:0] HLast = 16'(SCR_H - 1);

  logic [1:0]      r_state;
  logic            r_ph;
  logic [3:0]      r_idx;
  logic [10:0]     r_x;
  logic [10:0]     r_y;
  logic [15:0]     r_lcd_d;
  logic            r_lcd_wr_n;
  logic            r_lcd_rd_n;
  logic            r_lcd_cs_n;
  logic            r_lcd_rs;
  logic            r_frame_done;
  logic [15:0]     r_frame_cnt;
  logic [BgW-1:0]  r_bg_addr;
  logic [SprW-1:0] r_spr_addr;
  logic            r_hit;

  logic [10:0] r_stg_x   [NUM_SPRITES];
  logic [10:0] r_stg_y   [NUM_SPRITES];
  logic        r_stg_vis [NUM_SPRITES];
  logic [10:0] r_act_x   [NUM_SPRITES];
  logic [10:0] r_act_y   [NUM_SPRITES];
  logic        r_act_vis [NUM_SPRITES];

  logic [7:0]          w_setup_byte;
  logic                w_setup_rs;
  logic [10:0]         w_fx;
  logic [10:0]         w_fy;
  logic [11:0]         w_dx   [NUM_SPRITES];
  logic [11:0]         w_dy   [NUM_SPRITES];
  logic                w_hits [NUM_SPRITES];
  logic                w_hit;
  logic [2:0]          w_win;
  logic [SPR_LOG2-1:0] w_wdx;
  logic [SPR_LOG2-1:0] w_wdy;
  logic [15:0]         w_pix;
  logic                w_last;
  logic                w_start;

  assign o_lcd.d       = r_lcd_d;
  assign o_lcd.wr_n    = r_lcd_wr_n;
  assign o_lcd.rd_n    = r_lcd_rd_n;
  assign o_lcd.cs_n    = r_lcd_cs_n;
  assign o_lcd.rs      = r_lcd_rs;
  assign o_lcd.reset_n = i_bus.reset_n;
  assign o_bg_addr     = r_bg_addr;
  assign o_spr_addr    = r_spr_addr;
  assign o_frame_done  = r_frame_done;
  assign o_frame_cnt   = r_frame_cnt;

  always_comb begin
    w_setup_byte = 8'h00;
    w_setup_rs   = 1'b1;
    case (r_idx)
      4'd0:  begin w_setup_byte = 8'h2A; w_setup_rs = 1'b0; end
      4'd3:  w_setup_byte = WLast[15:8];
      4'd4:  w_setup_byte = WLast[7:0];
      4'd5:  begin w_setup_byte = 8'h2B; w_setup_rs = 1'b0; end
      4'd8:  w_setup_byte = HLast[15:8];
      4'd9:  w_setup_byte = HLast[7:0];
      4'd10: begin w_setup_byte = 8'h2C; w_setup_rs = 1'b0; end
      default: ;
    endcase
  end

  // Fetch cursor: the pixel whose memory reads are issued on this write's S edge.
  always_comb begin
    w_fx = 11'd0;
    w_fy = 11'd0;
    if (r_state == StPixel) begin
      if (r_x == XLast) begin
        w_fy = (r_y == YLast) ? 11'd0 : r_y + 11'd1;
      end else begin
        w_fx = r_x + 11'd1;
        w_fy = r_y;
      end
    end
  end

  // Unsigned 12-bit difference; the hit test rejects wrapped (negative) results.
  always_comb begin
    for (int i = 0; i < int'(NUM_SPRITES); i++) begin
      w_dx[i]   = {1'b0, w_fx} - {r_act_x[i][10], r_act_x[i]};
      w_dy[i]   = {1'b0, w_fy} - {r_act_y[i][10], r_act_y[i]};
      w_hits[i] = r_act_vis[i] && (w_dx[i][11:SPR_LOG2] == '0)
                               && (w_dy[i][11:SPR_LOG2] == '0);
    end
  end

  always_comb begin
    w_hit = 1'b0;
    w_win = 3'd0;
    w_wdx = '0;
    w_wdy = '0;
    for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
      if (w_hits[i]) begin
        w_hit = 1'b1;
        w_win = 3'(i);
        w_wdx = w_dx[i][SPR_LOG2-1:0];
        w_wdy = w_dy[i][SPR_LOG2-1:0];
      end
    end
  end

  assign w_pix   = (r_hit && (i_spr_rdata != KEY_COLOR)) ? i_spr_rdata : i_bg_rdata;
  assign w_last  = (r_x == XLast) && (r_y == YLast);
  assign w_start = i_buffer_en && ((r_state == StIdle) ||
                                   ((r_state == StPixel) && r_ph && w_last));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_ph         <= 1'b0;
      r_idx        <= 4'd0;
      r_x          <= 11'd0;
      r_y          <= 11'd0;
      r_lcd_d      <= 16'h0000;
      r_lcd_wr_n   <= 1'b1;
      r_lcd_rd_n   <= 1'b1;
      r_lcd_cs_n   <= 1'b1;
      r_lcd_rs     <= 1'b1;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 16'h0000;
      r_bg_addr    <= '0;
      r_spr_addr   <= '0;
      r_hit        <= 1'b0;
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        r_stg_x[i]   <= 11'd0;
        r_stg_y[i]   <= 11'd0;
        r_stg_vis[i] <= 1'b0;
        r_act_x[i]   <= 11'd0;
        r_act_y[i]   <= 11'd0;
        r_act_vis[i] <= 1'b0;
      end
    end else begin
      r_frame_done <= 1'b0;
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        if (i_spr_wr && (i_spr_sel == 3'(i))) begin
          r_stg_x[i]   <= i_spr_x;
          r_stg_y[i]   <= i_spr_y;
          r_stg_vis[i] <= i_spr_vis;
        end
      end

      if (r_state == StIdle) begin
        r_lcd_d    <= i_bus.d;
        r_lcd_wr_n <= i_bus.wr_n;
        r_lcd_rd_n <= i_bus.rd_n;
        r_lcd_cs_n <= i_bus.cs_n;
        r_lcd_rs   <= i_bus.rs;
      end else if (!r_ph) begin
        if (!i_buffer_en) begin
          r_state <= StIdle;
        end else begin
          r_ph       <= 1'b1;
          r_lcd_cs_n <= 1'b0;
          r_lcd_wr_n <= 1'b0;
          r_lcd_rd_n <= 1'b1;
          r_bg_addr  <= {w_fy[TILE_H_LOG2-1:0], w_fx[TILE_W_LOG2-1:0]};
          r_spr_addr <= {w_win, w_wdy, w_wdx};
          r_hit      <= w_hit;
          if (r_state == StSetup) begin
            r_lcd_d  <= {8'h00, w_setup_byte};
            r_lcd_rs <= w_setup_rs;
          end else begin
            r_lcd_d  <= w_pix;
            r_lcd_rs <= 1'b1;
          end
        end
      end else begin
        r_ph       <= 1'b0;
        r_lcd_wr_n <= 1'b1;
        r_lcd_cs_n <= 1'b1;
        if (r_state == StSetup) begin
          r_idx <= r_idx + 4'd1;
          if (!i_buffer_en) begin
            r_state <= StIdle;
          end else if (r_idx == 4'd10) begin
            r_state <= StPixel;
          end
        end else if (w_last) begin
          r_frame_done <= 1'b1;
          r_frame_cnt  <= r_frame_cnt + 16'd1;
          r_state      <= StIdle;
        end else begin
          if (r_x == XLast) begin
            r_x <= 11'd0;
            r_y <= r_y + 11'd1;
          end else begin
            r_x <= r_x + 11'd1;
          end
          if (!i_buffer_en) begin
            r_state <= StIdle;
          end
        end
      end

      // Staging is latched only here, so a frame never sees a half-updated set.
      if (w_start) begin
        r_state <= StSetup;
        r_ph    <= 1'b0;
        r_idx   <= 4'd0;
        r_x     <= 11'd0;
        r_y     <= 11'd0;
        for (int i = 0; i < int'(NUM_SPRITES); i++) begin
          r_act_x[i]   <= r_stg_x[i];
          r_act_y[i]   <= r_stg_y[i];
          r_act_vis[i] <= r_stg_vis[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_lt24_sprite_compositor.sv
// Directed bench for lt24_sprite_compositor on a small 8x4 screen with 4x4 sprites
// and a 4x2 background tile.
module tb_lt24_sprite_compositor;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NSPR = 4;
  localparam logic [15:0] KEY = 16'hF81F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        buffer_en = 1'b0;
  logic        spr_wr = 1'b0;
  logic [2:0]  spr_sel = 3'd0;
  logic [10:0] spr_x = 11'd0;
  logic [10:0] spr_y = 11'd0;
  logic        spr_vis = 1'b0;
  logic [2:0]  bg_addr;
  logic [15:0] bg_rdata = 16'h0;
  logic [6:0]  spr_addr;
  logic [15:0] spr_rdata = 16'h0;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int m_stg_x [NSPR];
  int m_stg_y [NSPR];
  bit m_stg_v [NSPR];
  int m_pnd_x [NSPR];
  int m_pnd_y [NSPR];
  bit m_pnd_v [NSPR];
  int m_act_x [NSPR];
  int m_act_y [NSPR];
  bit m_act_v [NSPR];

  lt24_sprite_compositor_if bus ();
  lt24_sprite_compositor_if lcd ();

  lt24_sprite_compositor #(
    .SCR_W      (W),
    .SCR_H      (H),
    .TILE_W_LOG2(2),
    .TILE_H_LOG2(1),
    .SPR_LOG2   (2),
    .NUM_SPRITES(NSPR),
    .KEY_COLOR  (KEY)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_buffer_en (buffer_en),
    .i_bus       (bus),
    .o_lcd       (lcd),
    .i_spr_wr    (spr_wr),
    .i_spr_sel   (spr_sel),
    .i_spr_x     (spr_x),
    .i_spr_y     (spr_y),
    .i_spr_vis   (spr_vis),
    .o_bg_addr   (bg_addr),
    .i_bg_rdata  (bg_rdata),
    .o_spr_addr  (spr_addr),
    .i_spr_rdata (spr_rdata),
    .o_frame_done(frame_done),
    .o_frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bg_fn(input logic [2:0] a);
    return 16'h4000 | 16'(a);
  endfunction

  // Sprite 0 column 1 is transparent.
  function automatic logic [15:0] spr_fn(input logic [6:0] a);
    if (a[6:4] == 3'd0 && a[1:0] == 2'd1) return KEY;
    return 16'h8000 | 16'(a);
  endfunction

  always @(posedge clk) begin
    bg_rdata  <= bg_fn(bg_addr);
    spr_rdata <= spr_fn(spr_addr);
  end

  function automatic logic [15:0] exp_pix(input int x, input int y);
    logic [2:0] ba;
    ba = {1'(y % 2), 2'(x % 4)};
    for (int i = 0; i < NSPR; i++) begin
      int dx;
      int dy;
      logic [6:0] a;
      dx = x - m_act_x[i];
      dy = y - m_act_y[i];
      if (m_act_v[i] && dx >= 0 && dx < 4 && dy >= 0 && dy < 4) begin
        a = {3'(i), 2'(dy), 2'(dx)};
        if (spr_fn(a) != KEY) return spr_fn(a);
        return bg_fn(ba);
      end
    end
    return bg_fn(ba);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic        rs;
  } setup_t;

  typedef struct {
    logic [15:0] d;
    logic        wr_n, rd_n, cs_n, rs;
    logic [19:0] exp;
  } pt_vec_t;

  setup_t  setup_tab [11];
  pt_vec_t pt_tab [5];

  task automatic set_sprite(input logic [2:0] sel, input int sx, input int sy, input bit vis);
    spr_wr  = 1'b1;
    spr_sel = sel;
    spr_x   = 11'(sx);
    spr_y   = 11'(sy);
    spr_vis = vis;
    @(posedge clk);
    #1;
    spr_wr = 1'b0;
    if (sel < NSPR) begin
      m_stg_x[sel] = sx;
      m_stg_y[sel] = sy;
      m_stg_v[sel] = vis;
    end
    @(negedge clk);
  endtask

  // Raise buffer_en and let the entry edge pass.
  task automatic start_from_idle();
    buffer_en = 1'b1;
    m_pnd_x = m_stg_x;
    m_pnd_y = m_stg_y;
    m_pnd_v = m_stg_v;
    @(posedge clk);
    #1;
  endtask

  // Captures one frame starting right after its start edge; optional sprite write after
  // the sample of cycle wr_cyc; stop drops buffer_en so the frame ends in IDLE.
  task automatic run_frame(input string tag, input int wr_cyc, input logic [2:0] sel,
                           input int sx, input int sy, input bit vis, input bit stop);
    logic [16:0] wlog [64];
    int nw;
    int perr;
    int done_at;
    bit prev_s;
    logic [15:0] pd;
    logic prs;
    nw = 0; perr = 0; done_at = -1; prev_s = 1'b0; pd = '0; prs = 1'b0;
    for (int i = 0; i < 64; i++) wlog[i] = 'x;
    m_act_x = m_pnd_x;
    m_act_y = m_pnd_y;
    m_act_v = m_pnd_v;
    for (int c = 1; c <= 200; c++) begin
      if (c == 86) begin
        m_pnd_x = m_stg_x;
        m_pnd_y = m_stg_y;
        m_pnd_v = m_stg_v;
      end
      @(posedge clk);
      #1;
      if (spr_wr) begin
        spr_wr = 1'b0;
        if (sel < NSPR) begin
          m_stg_x[sel] = sx;
          m_stg_y[sel] = sy;
          m_stg_v[sel] = vis;
        end
      end
      @(negedge clk);
      if (lcd.rd_n !== 1'b1) perr++;
      if (prev_s) begin
        if (lcd.wr_n !== 1'b1 || lcd.cs_n !== 1'b1 || lcd.d !== pd || lcd.rs !== prs) perr++;
        prev_s = 1'b0;
      end else if (lcd.cs_n === 1'b0 && lcd.wr_n === 1'b0) begin
        if (nw < 64) wlog[nw] = {lcd.rs, lcd.d};
        nw++;
        prev_s = 1'b1;
        pd = lcd.d;
        prs = lcd.rs;
      end else if (lcd.cs_n !== 1'b1 || lcd.wr_n !== 1'b1) begin
        perr++;
      end
      if (c == wr_cyc) begin
        spr_wr  = 1'b1;
        spr_sel = sel;
        spr_x   = 11'(sx);
        spr_y   = 11'(sy);
        spr_vis = vis;
      end
      if (stop && c == 85) buffer_en = 1'b0;
      if (frame_done === 1'b1) begin
        done_at = c;
        break;
      end
    end
    check({tag, " frame_done cycle"}, 32'(done_at), 32'd86);
    check({tag, " write count"}, 32'(nw), 32'(11 + W * H));
    check({tag, " bus protocol errors"}, 32'(perr), 32'd0);
    for (int i = 0; i < 11; i++)
      check($sformatf("%s setup%0d", tag, i), 32'(wlog[i]), 32'({setup_tab[i].rs, setup_tab[i].d}));
    for (int p = 0; p < W * H; p++)
      check($sformatf("%s pix(%0d,%0d)", tag, p % W, p / W), 32'(wlog[11 + p]),
            32'({1'b1, exp_pix(p % W, p / W)}));
  endtask

  initial begin
    bit saw_done;
    int nw;
    logic [15:0] cnt_before;

    setup_tab = '{'{16'h2A, 1'b0}, '{16'h00, 1'b1}, '{16'h00, 1'b1}, '{16'h00, 1'b1},
                  '{16'h07, 1'b1}, '{16'h2B, 1'b0}, '{16'h00, 1'b1}, '{16'h00, 1'b1},
                  '{16'h00, 1'b1}, '{16'h03, 1'b1}, '{16'h2C, 1'b0}};
    pt_tab = '{'{16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, {16'h1234, 4'b0101}},
               '{16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b0, {16'hA5C3, 4'b1000}},
               '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, {16'h0000, 4'b1111}},
               '{16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, {16'hFFFF, 4'b0100}},
               '{16'h5A5A, 1'b1, 1'b1, 1'b0, 1'b1, {16'h5A5A, 4'b1101}}};
    for (int i = 0; i < NSPR; i++) begin
      m_stg_x[i] = 0; m_stg_y[i] = 0; m_stg_v[i] = 1'b0;
    end
    m_pnd_x = m_stg_x; m_pnd_y = m_stg_y; m_pnd_v = m_stg_v;

    // Reset with a busy CPU bus: reset values must win.
    bus.d = 16'h1234; bus.wr_n = 1'b0; bus.rd_n = 1'b0; bus.cs_n = 1'b0;
    bus.rs = 1'b0; bus.reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset lcd_d", 32'(lcd.d), 32'h0);
    check("reset lcd_wr_n", 32'(lcd.wr_n), 32'd1);
    check("reset lcd_rd_n", 32'(lcd.rd_n), 32'd1);
    check("reset lcd_cs_n", 32'(lcd.cs_n), 32'd1);
    check("reset lcd_rs", 32'(lcd.rs), 32'd1);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset frame_cnt", 32'(frame_cnt), 32'd0);
    bus.reset_n = 1'b0;
    #1 check("lcd_reset_n low", 32'(lcd.reset_n), 32'd0);
    bus.reset_n = 1'b1;
    #1 check("lcd_reset_n high", 32'(lcd.reset_n), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      bus.d = pt_tab[i].d; bus.wr_n = pt_tab[i].wr_n; bus.rd_n = pt_tab[i].rd_n;
      bus.cs_n = pt_tab[i].cs_n; bus.rs = pt_tab[i].rs;
      @(negedge clk);
      check($sformatf("pass-through vec%0d", i),
            32'({lcd.d, lcd.wr_n, lcd.rd_n, lcd.cs_n, lcd.rs}), 32'(pt_tab[i].exp));
    end
    bus.d = 16'h0; bus.wr_n = 1'b1; bus.rd_n = 1'b1; bus.cs_n = 1'b1; bus.rs = 1'b1;

    // Out-of-range index must be ignored; frame 1 is background only.
    set_sprite(3'd5, 0, 0, 1'b1);
    start_from_idle();
    run_frame("f1", -1, 3'd0, 0, 0, 1'b0, 1'b1);
    check("f1 frame_cnt", 32'(frame_cnt), 32'd1);
    @(negedge clk);

    // Overlap + key; mid-frame move of sprite 0 to (-3,-2) lands in the next frame.
    set_sprite(3'd1, 2, 1, 1'b1);
    set_sprite(3'd0, 3, 1, 1'b1);
    start_from_idle();
    run_frame("f2", 40, 3'd0, -3, -2, 1'b1, 1'b0);
    check("f2 frame_cnt", 32'(frame_cnt), 32'd2);
    // Write in the same clock as the next frame start: not seen until one frame later.
    run_frame("f3", 85, 3'd1, 2, 1, 1'b0, 1'b0);
    check("f3 frame_cnt", 32'(frame_cnt), 32'd3);
    run_frame("f4", -1, 3'd0, 0, 0, 1'b0, 1'b0);
    run_frame("f5", -1, 3'd0, 0, 0, 1'b0, 1'b1);
    check("f5 frame_cnt", 32'(frame_cnt), 32'd5);
    @(negedge clk);

    // Abort at pixel 10 phase S.
    cnt_before = frame_cnt;
    saw_done = 1'b0;
    nw = 0;
    m_act_x = m_stg_x; m_act_y = m_stg_y; m_act_v = m_stg_v;
    start_from_idle();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (frame_done === 1'b1) saw_done = 1'b1;
      if (lcd.cs_n === 1'b0 && lcd.wr_n === 1'b0) nw++;
      if (nw == 22) break;
    end
    check("abort reached pixel 10", 32'(nw), 32'd22);
    check("abort pixel 10 data", 32'(lcd.d), 32'(exp_pix(2, 1)));
    buffer_en = 1'b0;
    bus.d = 16'hBEEF; bus.wr_n = 1'b0; bus.rd_n = 1'b0; bus.cs_n = 1'b0; bus.rs = 1'b0;
    @(negedge clk);
    if (frame_done === 1'b1) saw_done = 1'b1;
    check("abort phase H", 32'({lcd.wr_n, lcd.cs_n, lcd.rs, lcd.d}),
          32'({1'b1, 1'b1, 1'b1, exp_pix(2, 1)}));
    @(negedge clk);
    if (frame_done === 1'b1) saw_done = 1'b1;
    check("abort pass-through", 32'({lcd.d, lcd.wr_n, lcd.rd_n, lcd.cs_n, lcd.rs}),
          32'({16'hBEEF, 4'b0000}));
    check("abort no frame_done", 32'(saw_done), 32'd0);
    check("abort frame_cnt", 32'(frame_cnt), 32'(cnt_before));
    bus.d = 16'h0; bus.wr_n = 1'b1; bus.rd_n = 1'b1; bus.cs_n = 1'b1; bus.rs = 1'b1;
    @(negedge clk);

    start_from_idle();
    run_frame("f6", -1, 3'd0, 0, 0, 1'b0, 1'b1);
    check("f6 frame_cnt", 32'(frame_cnt), 32'(cnt_before + 16'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
